branch_predict_unit: RTL and testbench

//  Parametrised branch resolution plus dynamic predictor: direct-mapped BTB with 2-bit saturating counters.
//  IF stage reads prediction for the fetch PC. EX stage resolves BNE/BEQ/BGZ/BLZ, updates the table and flags mispredicts.

---
 rtl/branch_predict_unit_pkg.sv | 22 ++
 rtl/branch_predict_unit_sat_counter.sv | 17 +
 rtl/branch_predict_unit.sv | 140 ++++++++++++++
 tb/tb_branch_predict_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predict_unit_pkg.sv
// Shared opcode values, word size and 2-bit predictor counter encodings for branch_predict_unit.
package branch_predict_unit_pkg;
  localparam int WORD_SIZE = 16;

  localparam logic [3:0] OPCODE_ADD = 4'h0;
  localparam logic [3:0] OPCODE_BEQ = 4'h4;
  localparam logic [3:0] OPCODE_BNE = 4'h5;
  localparam logic [3:0] OPCODE_BGZ = 4'h6;
  localparam logic [3:0] OPCODE_BLZ = 4'h7;

  typedef enum logic [1:0] {
    BP_CTR_SNT = 2'b00,
    BP_CTR_WNT = 2'b01,
    BP_CTR_WT  = 2'b10,
    BP_CTR_ST  = 2'b11
  } bp_ctr_e;

  function automatic logic is_branch_op(input logic [3:0] op);
    return (op == OPCODE_BEQ) || (op == OPCODE_BNE) ||
           (op == OPCODE_BGZ) || (op == OPCODE_BLZ);
  endfunction
endpackage

// File: rtl/branch_predict_unit_sat_counter.sv
// 2-bit saturating up/down counter, next-state only; the state lives in the caller's table.
module bp_sat_counter
  import branch_predict_unit_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       up,
  output logic [1:0] ctr_nxt
);
  always_comb begin
    ctr_nxt = ctr;
    if (up) begin
      if (ctr != BP_CTR_ST) ctr_nxt = ctr + 2'd1;
    end else begin
      if (ctr != BP_CTR_SNT) ctr_nxt = ctr - 2'd1;
    end
  end
endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit counters: IF-stage prediction, EX-stage resolve, update and flush.
// Optional gshare indexing is enabled by defining BP_GSHARE_EN.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int IDX_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] if_pc,
  output logic              pred_taken,
  output logic [WORD_W-1:0] pred_target,
  output logic [IDX_W-1:0]  pred_idx,
  input  logic              ex_valid,
  input  logic [WORD_W-1:0] ex_instr,
  input  logic [WORD_W-1:0] ex_pc,
  input  logic [WORD_W-1:0] ex_data1,
  input  logic [WORD_W-1:0] ex_data2,
  input  logic [WORD_W-1:0] ex_target,
  input  logic              ex_pred_taken,
  input  logic [WORD_W-1:0] ex_pred_target,
  input  logic [IDX_W-1:0]  ex_pred_idx,
  output logic              mispredict,
  output logic [WORD_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = WORD_W - IDX_W;

  logic              valid_q [ENTRIES];
  logic [1:0]        ctr_q   [ENTRIES];
  logic [TAG_W-1:0]  tag_q   [ENTRIES];
  logic [WORD_W-1:0] tgt_q   [ENTRIES];

  logic [IDX_W-1:0]  rd_idx;
  logic [3:0]        opcode;
  logic              is_branch;
  logic              taken;
  logic              resolve;
  logic              alias_hit;
  logic              upd_hit;
  logic [1:0]        ctr_nxt;
  logic [WORD_W-1:0] ex_pc_inc;
  logic              unused_instr_bits;

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ghr_q <= '0;
    else if (resolve) ghr_q <= {ghr_q[IDX_W-2:0], taken};
  end

  assign rd_idx = if_pc[IDX_W-1:0] ^ ghr_q;
`else
  assign rd_idx = if_pc[IDX_W-1:0];
`endif

  // Read path is purely combinational off the registered table: no write bypass.
  assign pred_idx    = rd_idx;
  assign pred_taken  = valid_q[rd_idx] && (tag_q[rd_idx] == if_pc[WORD_W-1:IDX_W]) && ctr_q[rd_idx][1];
  assign pred_target = tgt_q[rd_idx];

  assign opcode            = ex_instr[WORD_W-1:WORD_W-4];
  assign unused_instr_bits = ^ex_instr[WORD_W-5:0];
  assign is_branch         = is_branch_op(opcode);

  always_comb begin
    taken = 1'b0;
    case (opcode)
      OPCODE_BNE: taken = (ex_data1 != ex_data2);
      OPCODE_BEQ: taken = (ex_data1 == ex_data2);
      OPCODE_BGZ: taken = ($signed(ex_data1) > $signed({WORD_W{1'b0}}));
      OPCODE_BLZ: taken = ex_data1[WORD_W-1];
      default:    taken = 1'b0;
    endcase
  end

  assign resolve   = ex_valid && is_branch;
  assign alias_hit = ex_valid && !is_branch && ex_pred_taken;
  assign ex_pc_inc = ex_pc + WORD_W'(1);

  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = ex_pc_inc;
    if (resolve) begin
      mispredict = (taken != ex_pred_taken) || (taken && (ex_pred_target != ex_target));
      if (taken) redirect_pc = ex_target;
    end else if (alias_hit) begin
      mispredict = 1'b1;
    end
  end

  assign upd_hit = valid_q[ex_pred_idx] && (tag_q[ex_pred_idx] == ex_pc[WORD_W-1:IDX_W]);

  bp_sat_counter u_sat_counter (
    .ctr     (ctr_q[ex_pred_idx]),
    .up      (taken),
    .ctr_nxt (ctr_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= BP_CTR_WNT;
      end
    end else if (resolve) begin
      if (upd_hit) begin
        ctr_q[ex_pred_idx] <= ctr_nxt;
      end else if (taken) begin
        valid_q[ex_pred_idx] <= 1'b1;
        ctr_q[ex_pred_idx]   <= BP_CTR_WT;
      end
    end else if (alias_hit) begin
      valid_q[ex_pred_idx] <= 1'b0;
    end
  end

  // Tag and target are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (resolve && taken) begin
      tgt_q[ex_pred_idx] <= ex_target;
      if (!upd_hit) tag_q[ex_pred_idx] <= ex_pc[WORD_W-1:IDX_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (resolve)    branch_cnt  <= branch_cnt + CNT_W'(1);
      if (mispredict) mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural BTB model.
module tb_branch_predict_unit;
  import branch_predict_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] if_pc;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic [3:0]  pred_idx;
  logic        ex_valid;
  logic [15:0] ex_instr, ex_pc, ex_data1, ex_data2, ex_target, ex_pred_target;
  logic        ex_pred_taken;
  logic [3:0]  ex_pred_idx;
  logic        mispredict;
  logic [15:0] redirect_pc;
  logic [15:0] branch_cnt, mispred_cnt;

  always #5 clk = ~clk;

  branch_predict_unit #(.WORD_W(16), .IDX_W(4), .CNT_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .pred_idx       (pred_idx),
    .ex_valid       (ex_valid),
    .ex_instr       (ex_instr),
    .ex_pc          (ex_pc),
    .ex_data1       (ex_data1),
    .ex_data2       (ex_data2),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .ex_pred_idx    (ex_pred_idx),
    .mispredict     (mispredict),
    .redirect_pc    (redirect_pc),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model of the table, counters and history
  bit m_valid [16];
  int m_tag   [16];
  int m_tgt   [16];
  int m_ctr   [16];
  int m_bcnt, m_mcnt, m_ghr;

  function automatic void m_clear();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 1;
    end
    m_bcnt = 0;
    m_mcnt = 0;
    m_ghr  = 0;
  endfunction

  function automatic int m_index(input int pc);
`ifdef BP_GSHARE_EN
    return (pc ^ m_ghr) & 15;
`else
    return pc & 15;
`endif
  endfunction

  function automatic bit m_hit_at(input int idx, input int pc);
    return m_valid[idx] && (m_tag[idx] == (pc >> 4));
  endfunction

  function automatic bit m_pred(input int pc);
    int idx = m_index(pc);
    return m_hit_at(idx, pc) && (m_ctr[idx] >= 2);
  endfunction

  function automatic int m_pred_tgt(input int pc);
    return m_tgt[m_index(pc)];
  endfunction

  function automatic int sx(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  function automatic bit m_is_br(input int op);
    return op == OPCODE_BEQ || op == OPCODE_BNE || op == OPCODE_BGZ || op == OPCODE_BLZ;
  endfunction

  function automatic bit m_taken(input int op, input int d1, input int d2);
    if (op == OPCODE_BNE) return d1 != d2;
    if (op == OPCODE_BEQ) return d1 == d2;
    if (op == OPCODE_BGZ) return sx(d1) > 0;
    if (op == OPCODE_BLZ) return sx(d1) < 0;
    return 0;
  endfunction

  // One pipeline cycle: drive, check combinational outputs at negedge, advance the model at posedge.
  task automatic step(input int ifpc, input bit v, input int op, input int pc,
                      input int d1, input int d2, input int tgt, input bit pt, input int ptgt);
    int  pidx, e_idx, e_redir;
    bit  br, tk, res, ali, e_mis, e_pt, hit;
    pidx           = m_index(pc);
    if_pc          = 16'(ifpc);
    ex_valid       = v;
    ex_instr       = 16'((op << 12) | ($urandom & 12'hFFF));
    ex_pc          = 16'(pc);
    ex_data1       = 16'(d1);
    ex_data2       = 16'(d2);
    ex_target      = 16'(tgt);
    ex_pred_taken  = pt;
    ex_pred_target = 16'(ptgt);
    ex_pred_idx    = 4'(pidx);
    @(negedge clk);
    e_idx = m_index(ifpc);
    e_pt  = m_pred(ifpc);
    check("pred_taken", {31'd0, pred_taken}, {31'd0, e_pt});
    check("pred_idx", {28'd0, pred_idx}, 32'(e_idx));
    if (e_pt) check("pred_target", {16'd0, pred_target}, 32'(m_pred_tgt(ifpc)));
    br      = m_is_br(op);
    tk      = m_taken(op, d1, d2);
    res     = v && br;
    ali     = v && !br && pt;
    e_mis   = res ? ((tk != pt) || (tk && ptgt != tgt)) : ali;
    e_redir = (res && tk) ? tgt : ((pc + 1) % 65536);
    check("mispredict", {31'd0, mispredict}, {31'd0, e_mis});
    check("redirect_pc", {16'd0, redirect_pc}, 32'(e_redir));
    check("branch_cnt", {16'd0, branch_cnt}, 32'(m_bcnt));
    check("mispred_cnt", {16'd0, mispred_cnt}, 32'(m_mcnt));
    @(posedge clk);
    hit = m_hit_at(pidx, pc);
    if (res) begin
      if (hit) begin
        m_ctr[pidx] = tk ? ((m_ctr[pidx] == 3) ? 3 : m_ctr[pidx] + 1)
                         : ((m_ctr[pidx] == 0) ? 0 : m_ctr[pidx] - 1);
        if (tk) m_tgt[pidx] = tgt;
      end else if (tk) begin
        m_valid[pidx] = 1;
        m_tag[pidx]   = pc >> 4;
        m_tgt[pidx]   = tgt;
        m_ctr[pidx]   = 2;
      end
      m_bcnt = (m_bcnt + 1) % 65536;
      m_ghr  = ((m_ghr << 1) | int'(tk)) & 15;
    end else if (ali) begin
      m_valid[pidx] = 0;
    end
    if (e_mis) m_mcnt = (m_mcnt + 1) % 65536;
    #1;
  endtask

  int pc_pool  [8] = '{16'h0010, 16'h0030, 16'h0013, 16'h0023, 16'hFFFF, 16'h1234, 16'h0000, 16'h00F7};
  int tgt_pool [4] = '{16'h0020, 16'h0100, 16'h7FF0, 16'h0011};
  int op_pool  [6] = '{OPCODE_BNE, OPCODE_BEQ, OPCODE_BGZ, OPCODE_BLZ, OPCODE_ADD, 4'h9};
  int d_pool   [6] = '{0, 1, 16'h7FFF, 16'h8000, 16'hFFFF, 5};

  task automatic reset_mid();
    ex_valid = 1'b0;
    ex_pred_taken = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_branch_cnt", {16'd0, branch_cnt}, 32'd0);
    check("rst_mispred_cnt", {16'd0, mispred_cnt}, 32'd0);
    check("rst_mispredict", {31'd0, mispredict}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      if_pc = 16'(pc_pool[k]);
      #1;
      check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    end
    m_clear();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pc, op, d1, d2, tg;
    bit pt;
    int ptg;
    reset = 1'b1;
    if_pc = '0; ex_valid = 0; ex_instr = '0; ex_pc = '0; ex_data1 = '0; ex_data2 = '0;
    ex_target = '0; ex_pred_taken = 0; ex_pred_target = '0; ex_pred_idx = '0;
    m_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Empty table after reset
    step(16'h0010, 0, OPCODE_ADD, 16'h0000, 0, 0, 0, 0, 0);
    check("t1_branch_cnt", {16'd0, branch_cnt}, 32'd0);

    // BEQ taken, predicted not-taken: allocate
    step(16'h0010, 1, OPCODE_BEQ, 16'h0010, 5, 5, 16'h0020, 0, 0);
`ifndef BP_GSHARE_EN
    check("t2_pred_after_alloc", {31'd0, pred_taken}, 32'd1);
    check("t2_target_after_alloc", {16'd0, pred_target}, 32'h0020);
`endif

    // Saturate up, then two not-taken to drop below threshold
    repeat (3) step(16'h0010, 1, OPCODE_BEQ, 16'h0010, 5, 5, 16'h0020, m_pred(16'h0010), m_pred_tgt(16'h0010));
    step(16'h0010, 1, OPCODE_BEQ, 16'h0010, 5, 6, 16'h0020, m_pred(16'h0010), m_pred_tgt(16'h0010));
`ifndef BP_GSHARE_EN
    check("t3_pred_after_nt1", {31'd0, pred_taken}, 32'd1);
`endif
    step(16'h0010, 1, OPCODE_BEQ, 16'h0010, 5, 6, 16'h0020, m_pred(16'h0010), m_pred_tgt(16'h0010));
`ifndef BP_GSHARE_EN
    check("t3_pred_after_nt2", {31'd0, pred_taken}, 32'd0);
`endif

    // Signed compare: BGZ on negative, BLZ on -1
    step(16'h0040, 1, OPCODE_BGZ, 16'h0040, 16'h8000, 0, 16'h0050, 1, 16'h0050);
    step(16'h0040, 1, OPCODE_BLZ, 16'h0041, 16'hFFFF, 0, 16'h0060, 0, 0);

    // Re-arm index 0, then a non-branch at an aliased PC evicts it
    repeat (2) step(16'h0010, 1, OPCODE_BEQ, 16'h0010, 7, 7, 16'h0020, m_pred(16'h0010), m_pred_tgt(16'h0010));
    step(16'h0010, 1, OPCODE_ADD, 16'h0030, 1, 2, 0, 1, 16'h0020);
`ifndef BP_GSHARE_EN
    check("t5_alias_invalidated", {31'd0, pred_taken}, 32'd0);
`endif

    // PC wrap on not-taken
    step(16'hFFFF, 1, OPCODE_BNE, 16'hFFFF, 3, 3, 16'h0020, 0, 0);

    for (int i = 0; i < 600; i++) begin
      if (i == 300) reset_mid();
      pc  = pc_pool[$urandom_range(0, 7)];
      op  = op_pool[$urandom_range(0, 5)];
      d1  = ($urandom_range(0, 3) == 0) ? int'($urandom & 16'hFFFF) : d_pool[$urandom_range(0, 5)];
      d2  = $urandom_range(0, 1) ? d1 : d_pool[$urandom_range(0, 5)];
      tg  = tgt_pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 9) < 7) begin
        pt  = m_pred(pc);
        ptg = m_pred_tgt(pc);
      end else begin
        pt  = bit'($urandom_range(0, 1));
        ptg = tgt_pool[$urandom_range(0, 3)];
      end
      step(pc_pool[$urandom_range(0, 7)], $urandom_range(0, 9) < 9, op, pc, d1, d2, tg, pt, ptg);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
